// File: rtl/video_pattern_gen.sv
// video_pattern_gen
//   Test-pattern pixel source for a 24-bit ready/valid video sink. It walks a
//   Width x Height raster, one pixel per accepted transfer. Mode and Color are
//   latched only at frame start, so changes made mid-frame do not tear the
//   image.
//
// Handshake: a transfer happens on a rising Clock edge where VideoValid and
//   VideoReady are both high. While VideoValid is high and VideoReady is low,
//   Video, VideoValid and all internal state hold.
//
// Ports:
//   Clock       in   pixel clock
//   Reset       in   asynchronous, active-high reset
//   Enable      in   run request; sampled only at frame boundaries
//   Mode[2:0]   in   pattern select; sampled at frame start
//   Color[23:0] in   solid colour {R,G,B}; sampled at frame start
//   Video[23:0] out  pixel {R[23:16],G[15:8],B[7:0]}
//   VideoValid  out  Video holds a valid pixel
//   VideoReady  in   sink accepts the pixel this cycle
//   FrameDone   out  one-cycle pulse after the last pixel of a frame is accepted
//   Busy        out  high in the RUN state
//   dbg_state   out  FSM state (0 = IDLE, 1 = RUN)
//
// Optional feature (macro VIDEO_PATTERN_GEN_OVERLAY_EN): when defined, the
//   outline and the centre cross are forced to white in every mode.
module video_pattern_gen #(
    parameter int Width       = 800,
    parameter int Height      = 600,
    parameter int CheckerLog2 = 5
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Enable,
    input  logic [2:0]  Mode,
    input  logic [23:0] Color,
    output logic [23:0] Video,
    output logic        VideoValid,
    input  logic        VideoReady,
    output logic        FrameDone,
    output logic        Busy,
    output logic        dbg_state
);

    localparam int XW = (Width  > 1) ? $clog2(Width)  : 1;
    localparam int YW = (Height > 1) ? $clog2(Height) : 1;

    localparam logic [XW-1:0] X_LAST = XW'(Width - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(Height - 1);
    localparam logic [31:0]   BAR_W  = 32'(Width / 8);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [7:0]    frame_cnt_q, frame_cnt_d;
    logic [2:0]    mode_q, mode_d;
    logic [23:0]   color_q, color_d;
    logic [23:0]   video_q, video_d;
    logic          valid_q, valid_d;
    logic          frame_done_q, frame_done_d;

    logic          xfer;
    logic          last_pixel;

    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = 24'hFFFFFF;
            3'd1:    c = 24'hFFFF00;
            3'd2:    c = 24'h00FFFF;
            3'd3:    c = 24'h00FF00;
            3'd4:    c = 24'hFF00FF;
            3'd5:    c = 24'hFF0000;
            3'd6:    c = 24'h0000FF;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

    // Pixel value for coordinate (x,y) under the given mode/colour/frame count.
    function automatic logic [23:0] pattern_pixel(
        input logic [XW-1:0] x,
        input logic [YW-1:0] y,
        input logic [2:0]    mode,
        input logic [23:0]   color,
        input logic [7:0]    fcnt
    );
        logic [31:0] xe;
        logic [31:0] ye;
        logic [31:0] xs;
        logic [31:0] bar;
        logic        chk;
        logic        chk_scroll;
        logic [23:0] pix;
        xe  = 32'(x);
        ye  = 32'(y);
        xs  = xe + 32'(fcnt);
        // The last bar absorbs any remainder when Width is not a multiple of 8.
        bar = xe / BAR_W;
        if (bar > 32'd7) begin
            bar = 32'd7;
        end
        chk        = (((xe ^ ye) >> CheckerLog2) & 32'd1) != 32'd0;
        chk_scroll = (((xs ^ ye) >> CheckerLog2) & 32'd1) != 32'd0;
        case (mode)
            3'd0:    pix = color;
            3'd1:    pix = bar_color(bar[2:0]);
            3'd2:    pix = chk ? 24'hFFFFFF : 24'h000000;
            3'd3:    pix = {xe[7:0], xe[7:0], xe[7:0]};
            3'd4:    pix = {ye[7:0], ye[7:0], ye[7:0]};
            3'd5:    pix = chk_scroll ? 24'hFFFFFF : 24'h000000;
            default: pix = 24'h000000;
        endcase
`ifdef VIDEO_PATTERN_GEN_OVERLAY_EN
        if ((xe == 32'd0) || (xe == 32'(Width - 1)) || (xe == 32'(Width / 2)) ||
            (ye == 32'd0) || (ye == 32'(Height - 1)) || (ye == 32'(Height / 2))) begin
            pix = 24'hFFFFFF;
        end
`endif
        return pix;
    endfunction

    assign xfer       = valid_q && VideoReady;
    assign last_pixel = (x_q == X_LAST) && (y_q == Y_LAST);

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        frame_cnt_d  = frame_cnt_q;
        mode_d       = mode_q;
        color_d      = color_q;
        video_d      = video_q;
        valid_d      = valid_q;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (Enable) begin
                    mode_d  = Mode;
                    color_d = Color;
                    x_d     = '0;
                    y_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!valid_q) begin
                    // First cycle after leaving IDLE: present pixel (0,0).
                    valid_d = 1'b1;
                    video_d = pattern_pixel(x_q, y_q, mode_q, color_q, frame_cnt_q);
                end else if (xfer) begin
                    if (last_pixel) begin
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + 8'd1;
                        x_d          = '0;
                        y_d          = '0;
                        if (Enable) begin
                            // Back-to-back frame: the new frame's settings apply
                            // to its very first pixel, so use the inputs directly.
                            mode_d  = Mode;
                            color_d = Color;
                            video_d = pattern_pixel('0, '0, Mode, Color, frame_cnt_q + 8'd1);
                        end else begin
                            state_d = IDLE;
                            valid_d = 1'b0;
                        end
                    end else begin
                        if (x_q == X_LAST) begin
                            x_d = '0;
                            y_d = y_q + YW'(1);
                        end else begin
                            x_d = x_q + XW'(1);
                        end
                        video_d = pattern_pixel(x_d, y_d, mode_q, color_q, frame_cnt_q);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            frame_cnt_q  <= '0;
            mode_q       <= '0;
            color_q      <= '0;
            video_q      <= '0;
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            frame_cnt_q  <= frame_cnt_d;
            mode_q       <= mode_d;
            color_q      <= color_d;
            video_q      <= video_d;
            valid_q      <= valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign Video      = video_q;
    assign VideoValid = valid_q;
    assign FrameDone  = frame_done_q;
    assign Busy       = (state_q == RUN);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Testbench for video_pattern_gen (16x4 raster, 2-pixel checker squares).
// Stimulus pushes each frame's expected pixels into exp_q when it sets that
// frame's Mode/Color; a negedge monitor pops one entry per transfer and also
// checks FrameDone, stall stability and the return to idle.
module tb_video_pattern_gen;

    localparam int W   = 16;
    localparam int H   = 4;
    localparam int CL  = 1;
    localparam int FPX = W * H;

    logic        Clock;
    logic        Reset;
    logic        Enable;
    logic [2:0]  Mode;
    logic [23:0] Color;
    logic [23:0] Video;
    logic        VideoValid;
    logic        VideoReady;
    logic        FrameDone;
    logic        Busy;
    logic        dbg_state;

    logic [23:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          xfer_cnt = 0;
    int          ready_mode = 0;   // 0 always, 1 random, 2 pattern 1,0,0,1

    video_pattern_gen #(
        .Width(W),
        .Height(H),
        .CheckerLog2(CL)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .Enable(Enable),
        .Mode(Mode),
        .Color(Color),
        .Video(Video),
        .VideoValid(VideoValid),
        .VideoReady(VideoReady),
        .FrameDone(FrameDone),
        .Busy(Busy),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [23:0] model_bar(input int idx);
        case (idx)
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [23:0] model_pix(input int x, input int y, input int mode,
                                              input logic [23:0] col, input int fc);
        logic [23:0] p;
        int          idx;
        int          v;
        case (mode)
            0: p = col;
            1: begin
                idx = x / (W / 8);
                if (idx > 7) idx = 7;
                p = model_bar(idx);
            end
            2: p = ((((x >> CL) ^ (y >> CL)) & 1) == 1) ? 24'hFFFFFF : 24'h000000;
            3: begin v = x % 256; p = {8'(v), 8'(v), 8'(v)}; end
            4: begin v = y % 256; p = {8'(v), 8'(v), 8'(v)}; end
            5: p = (((((x + fc) >> CL) ^ (y >> CL)) & 1) == 1) ? 24'hFFFFFF : 24'h000000;
            default: p = 24'h000000;
        endcase
`ifdef VIDEO_PATTERN_GEN_OVERLAY_EN
        if (x == 0 || x == W - 1 || x == W / 2 || y == 0 || y == H - 1 || y == H / 2)
            p = 24'hFFFFFF;
`endif
        return p;
    endfunction

    task automatic push_frame(input int mode, input logic [23:0] col, input int fc);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                exp_q.push_back(model_pix(x, y, mode, col, fc % 256));
            end
        end
    endtask

    // ---------------- ready driver ----------------
    initial begin
        logic [3:0] pat;
        int         pat_idx;
        pat        = 4'b1001;
        pat_idx    = 0;
        VideoReady = 1'b1;
        forever begin
            @(posedge Clock);
            #1;
            case (ready_mode)
                1:       VideoReady = ($urandom_range(0, 3) != 0);
                2: begin
                    VideoReady = pat[3 - pat_idx];
                    pat_idx    = (pat_idx + 1) % 4;
                end
                default: VideoReady = 1'b1;
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic        prev_stall;
        logic [23:0] prev_video;
        logic        pend_done;
        logic        pend_idle;
        int          in_frame;
        logic [23:0] e;
        prev_stall = 1'b0;
        prev_video = '0;
        pend_done  = 1'b0;
        pend_idle  = 1'b0;
        in_frame   = 0;
        forever begin
            @(negedge Clock);
            if (Reset) begin
                prev_stall = 1'b0;
                pend_done  = 1'b0;
                pend_idle  = 1'b0;
                in_frame   = 0;
            end else begin
                check("frame_done", 32'(FrameDone), 32'(pend_done));
                if (pend_idle) begin
                    check("idle_valid", 32'(VideoValid), 32'd0);
                    check("idle_busy", 32'(Busy), 32'd0);
                end
                pend_done = 1'b0;
                pend_idle = 1'b0;
                if (prev_stall) begin
                    check("stall_valid", 32'(VideoValid), 32'd1);
                    check("stall_video", 32'(Video), 32'(prev_video));
                end
                if (VideoValid && VideoReady) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL pixel: got %h with no expected pixel queued", Video);
                    end else begin
                        e = exp_q.pop_front();
                        check("pixel", 32'(Video), 32'(e));
                    end
                    xfer_cnt++;
                    in_frame++;
                    if (in_frame == FPX) begin
                        in_frame  = 0;
                        pend_done = 1'b1;
                        pend_idle = !Enable;
                    end
                end
                prev_stall = VideoValid && !VideoReady;
                prev_video = Video;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_xfers(input int target);
        int guard;
        guard = 0;
        while (xfer_cnt < target && guard < 5000) begin
            @(posedge Clock);
            #1;
            guard++;
        end
        if (xfer_cnt < target) begin
            n_checks++;
            $display("FAIL wait_xfers: reached %0d transfers, required %0d", xfer_cnt, target);
        end
    endtask

    task automatic check_startup(input string tag);
        @(posedge Clock);
        #1;
        check({tag, "_edge1_valid"}, 32'(VideoValid), 32'd0);
        check({tag, "_edge1_busy"}, 32'(Busy), 32'd1);
        @(posedge Clock);
        #1;
        check({tag, "_edge2_valid"}, 32'(VideoValid), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    int          f_mode  [9] = '{1, 0, 3, 2, 5, 4, 6, 8, 7};   // 8 = random
    int          f_ready [9] = '{0, 2, 0, 1, 1, 1, 1, 1, 1};
    logic [23:0] f_color [9] = '{24'h000000, 24'h123456, 24'hABCDEF, 24'h0F0F0F,
                                 24'h00FF00, 24'h55AA55, 24'h112233, 24'h000000, 24'h445566};

    initial begin
        int          base;
        int          cur_mode;
        logic [23:0] cur_color;
        int          fc;
        logic [23:0] rc;

        Reset  = 1'b0;
        Enable = 1'b0;
        Mode   = 3'd1;
        Color  = 24'h0;
        #2;
        Reset = 1'b1;
        #1;
        check("reset_video", 32'(Video), 32'd0);
        check("reset_valid", 32'(VideoValid), 32'd0);
        check("reset_done", 32'(FrameDone), 32'd0);
        check("reset_busy", 32'(Busy), 32'd0);

        cur_mode  = f_mode[0];
        cur_color = f_color[0];
        push_frame(cur_mode, cur_color, 0);
        @(posedge Clock);
        @(posedge Clock);
        #1;
        Enable = 1'b1;
        Reset  = 1'b0;
        check_startup("start");

        // Nine back-to-back frames; settings for each are applied just before
        // its first pixel, and scrambled at pixel 20 to show they are ignored.
        fc = 0;
        for (int f = 0; f < 9; f++) begin
            base = f * FPX;
            wait_xfers(base + 20);
            Mode  = 3'((cur_mode + 3) % 8);
            Color = ~cur_color;
            if (f == 8) begin
                wait_xfers(base + 40);
                Enable = 1'b0;
            end
            wait_xfers(base + FPX - 1);
            fc++;
            if (f < 8) begin
                cur_mode  = (f_mode[f + 1] == 8) ? $urandom_range(0, 7) : f_mode[f + 1];
                cur_color = (f_mode[f + 1] == 8) ? 24'($urandom) : f_color[f + 1];
                Mode      = 3'(cur_mode);
                Color     = cur_color;
                push_frame(cur_mode, cur_color, fc);
                ready_mode = f_ready[f + 1];
            end
        end
        wait_xfers(9 * FPX);
        @(posedge Clock);
        #1;
        check("drop_valid", 32'(VideoValid), 32'd0);
        repeat (5) @(posedge Clock);
        #1;
        check("idle_hold_valid", 32'(VideoValid), 32'd0);
        check("idle_hold_busy", 32'(Busy), 32'd0);

        // Re-raise Enable: restart at (0,0) with the frame count carried on.
        rc     = 24'($urandom);
        Mode   = 3'd5;
        Color  = rc;
        push_frame(5, rc, fc);
        Enable = 1'b1;
        check_startup("restart");
        base = xfer_cnt;
        wait_xfers(base + 30);

        // Asynchronous reset mid-frame.
        #2;
        Reset = 1'b1;
        #1;
        check("midrst_video", 32'(Video), 32'd0);
        check("midrst_valid", 32'(VideoValid), 32'd0);
        check("midrst_done", 32'(FrameDone), 32'd0);
        check("midrst_busy", 32'(Busy), 32'd0);
        exp_q.delete();
        @(posedge Clock);
        @(posedge Clock);
        #1;
        check("midrst_hold_valid", 32'(VideoValid), 32'd0);
        push_frame(5, rc, 0);
        Reset = 1'b0;
        check_startup("postrst");
        base = xfer_cnt - 0;
        wait_xfers(base + 40);
        Enable = 1'b0;
        wait_xfers(base + FPX);

        // Reset during the FrameDone pulse clears it immediately.
        check("done_pulse", 32'(FrameDone), 32'd1);
        #1;
        Reset = 1'b1;
        #1;
        check("done_cleared", 32'(FrameDone), 32'd0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        check("final_valid", 32'(VideoValid), 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
